// File: rtl/cpu_harness_pkg.sv
// Shared types and helpers for the cpu trace harness.
package cpu_harness_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHoldRst,
    StRun,
    StDone
  } harness_state_t;

  // Upper bound on a packed trace entry; pack/unpack work at this width.
  localparam int unsigned MaxEntryW = 256;

  // Timestamp width; at least one bit so single-cycle runs still have a field.
  function automatic int unsigned ts_width(input int unsigned run_cycles);
    return (run_cycles > 1) ? $clog2(run_cycles) : 1;
  endfunction

  function automatic int unsigned entry_width(input int unsigned run_cycles,
                                              input int unsigned num_ch,
                                              input int unsigned data_w);
    return ts_width(run_cycles) + num_ch * data_w;
  endfunction

  // Entry layout is {timestamp, channel data}, timestamp in the MSBs.
  function automatic logic [MaxEntryW-1:0] pack_entry(input logic [MaxEntryW-1:0] ts,
                                                      input logic [MaxEntryW-1:0] data,
                                                      input int unsigned data_bits);
    return (ts << data_bits) | data;
  endfunction

  function automatic logic [MaxEntryW-1:0] entry_ts(input logic [MaxEntryW-1:0] entry,
                                                    input int unsigned data_bits);
    return entry >> data_bits;
  endfunction

  function automatic logic [MaxEntryW-1:0] entry_data(input logic [MaxEntryW-1:0] entry,
                                                      input int unsigned data_bits);
    return entry & ~({MaxEntryW{1'b1}} << data_bits);
  endfunction

endpackage

// File: rtl/cpu_trace_harness_fifo.sv
// Show-ahead trace FIFO with synchronous clear; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Drive zero when empty so the read port has a defined value out of reset.
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; no reset needed since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_trace_harness.sv
// Run-control and trace capture beside the cpu core: holds the core in reset,
// lets it run a fixed number of cycles and records time-stamped channel samples.
module cpu_trace_harness
  import cpu_harness_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned RST_CYCLES = 1,
  parameter int unsigned RUN_CYCLES = 32,
  parameter int unsigned DEPTH      = 32,
  localparam int unsigned TS_W      = ts_width(RUN_CYCLES),
  localparam int unsigned ENTRY_W   = entry_width(RUN_CYCLES, NUM_CH, DATA_W)
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     on_change,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     cpu_reset,
  output logic                     running,
  output logic                     done,
  output logic                     overflow,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ENTRY_W-1:0]       rd_data
);

  localparam int unsigned CH_W   = NUM_CH * DATA_W;
  localparam int unsigned HOLD_W = ts_width(RST_CYCLES);

  harness_state_t    state_q, state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [TS_W-1:0]   k_q;
  logic [CH_W-1:0]   last_q;
  logic              overflow_q;

  logic               clear, k_last, hold_last, push_req, push_ok, pop;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata;

  assign hold_last = (hold_q == HOLD_W'(RST_CYCLES - 1));
  assign k_last    = (k_q == TS_W'(RUN_CYCLES - 1));
  // A new run starts only from IDLE or DONE; it wipes the previous trace.
  assign clear     = start && ((state_q == StIdle) || (state_q == StDone));
  assign pop       = !fifo_empty && rd_ready;
  // Change detection compares against the last requested sample, dropped or not.
  assign push_req  = (state_q == StRun) &&
                     (!on_change || (k_q == '0) || (ch_data != last_q));
  assign push_ok   = push_req && (!fifo_full || pop);
  assign fifo_wdata = ENTRY_W'(pack_entry(MaxEntryW'(k_q), MaxEntryW'(ch_data), CH_W));

  assign overflow = overflow_q;
  assign rd_valid = !fifo_empty;

  // State register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state and decoded run-control outputs.
  always_comb begin
    state_d   = state_q;
    cpu_reset = 1'b0;
    running   = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cpu_reset = 1'b1;
        if (start) state_d = StHoldRst;
      end
      StHoldRst: begin
        cpu_reset = 1'b1;
        if (hold_last) state_d = StRun;
      end
      StRun: begin
        running = 1'b1;
        if (k_last) state_d = StDone;
      end
      StDone: begin
        done = 1'b1;
        if (start) state_d = StHoldRst;
      end
      default: begin
        cpu_reset = 1'b1;
        state_d   = StIdle;
      end
    endcase
  end

  // Hold/run counters, change-detect reference and sticky overflow.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      hold_q     <= '0;
      k_q        <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      hold_q     <= '0;
      k_q        <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (state_q == StHoldRst)       hold_q <= hold_q + HOLD_W'(1);
      if (state_q == StRun && !k_last) k_q   <= k_q + TS_W'(1);
      if (push_req)                   last_q <= ch_data;
      if (push_req && !push_ok)       overflow_q <= 1'b1;
    end
  end

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (reset),
    .clear (clear),
    .push  (push_ok),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
